// File: rtl/dca_matrix_lsu_wdata_packer_pkg.sv
// Shared DCA LSU definitions: store-path FSM encoding, element-size clamp, row/beat ratio.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dca_matrix_lsu_wdata_packer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Widest supported element is 32 bits; larger encodings alias to it.
    localparam logic [2:0] LSA_MAX = 3'd5;

    function automatic int row_beat_ratio(input int bw_row, input int bw_axi_data);
        return bw_row / bw_axi_data;
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_wdata_packer_strobe_gen.sv
// Reduces one beat-wide bit mask to AXI byte strobes (any set bit enables its byte).
// Latency: combinational.
// Backpressure: none.
module dca_wdata_strobe_gen #(
    parameter int BW_AXI_DATA = 64
) (
    input  logic [BW_AXI_DATA-1:0]   mask_slice,
    output logic [BW_AXI_DATA/8-1:0] wstrb
);

    for (genvar b = 0; b < BW_AXI_DATA/8; b++) begin : g_byte
        assign wstrb[b] = |mask_slice[b*8 +: 8];
    end

endmodule

// File: rtl/ervp_barrel_shifter.sv
// Logarithmic left barrel shifter with zero fill.
// Latency: combinational.
// Backpressure: none.
module ervp_barrel_shifter #(
    parameter int BW_DATA  = 256,
    parameter int BW_SHAMT = 8
) (
    input  logic [BW_DATA-1:0]  data_in,
    input  logic [BW_SHAMT-1:0] shamt,
    output logic [BW_DATA-1:0]  data_out
);

    logic [BW_DATA-1:0] stage [0:BW_SHAMT];

    assign stage[0] = data_in;

    for (genvar s = 0; s < BW_SHAMT; s++) begin : g_stage
        assign stage[s+1] = shamt[s] ? (stage[s] << (1 << s)) : stage[s];
    end

    assign data_out = stage[BW_SHAMT];

endmodule

// File: rtl/dca_matrix_lsu_wdata_packer.sv
// Packs a masked matrix row into an AXI W burst; DCA_LSU_WDATA_SUBBYTE_EN enables bit-granular offsets.
// Latency: first wvalid one cycle after row accept, then one beat per cycle while wready is high.
// Backpressure: wready low holds the current beat; row_ready only in IDLE once done has cleared.
module dca_matrix_lsu_wdata_packer
    import dca_matrix_lsu_wdata_packer_pkg::*;
#(
    parameter int BW_ROW      = 256,
    parameter int BW_AXI_DATA = 64,
    parameter int BW_OFFSET   = 8,
    parameter int NUM_COL     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [BW_ROW-1:0]        row_data,
    input  logic [NUM_COL-1:0]       row_colmask,
    input  logic [2:0]               row_elem_lsa,
    input  logic [BW_OFFSET-1:0]     row_bitaddr,
    input  logic [7:0]               row_alen,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [BW_AXI_DATA-1:0]   wdata,
    output logic [BW_AXI_DATA/8-1:0] wstrb,
    output logic                     wlast,
    output logic                     done
);

    localparam int RATIO   = row_beat_ratio(BW_ROW, BW_AXI_DATA);
    localparam int BW_STRB = BW_AXI_DATA / 8;
    localparam int BW_COL  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int BW_BEAT = 9;

    logic [0:0]               state;
    logic [BW_BEAT-1:0]       beat_cnt;
    logic [BW_BEAT-1:0]       beats;
    logic [BW_ROW-1:0]        data_buf;
    logic [BW_ROW-1:0]        mask_buf;

    logic [2:0]               lsa_eff;
    logic [BW_OFFSET-1:0]     eff_offset;
    logic [BW_ROW-1:0]        mask_exp;
    logic [BW_ROW-1:0]        data_sh;
    logic [BW_ROW-1:0]        mask_sh;
    logic [BW_AXI_DATA-1:0]   data_slice;
    logic [BW_AXI_DATA-1:0]   mask_slice;
    logic [BW_STRB-1:0]       strb_raw;

    assign lsa_eff = (row_elem_lsa > LSA_MAX) ? LSA_MAX : row_elem_lsa;

`ifdef DCA_LSU_WDATA_SUBBYTE_EN
    assign eff_offset = row_bitaddr;
`else
    logic unused_subbyte_bits;
    assign unused_subbyte_bits = ^row_bitaddr[2:0];
    assign eff_offset = {row_bitaddr[BW_OFFSET-1:3], 3'b000};
`endif

    // Each element spans 2**lsa bits; columns beyond NUM_COL never enable anything.
    always_comb begin
        int col;
        mask_exp = '0;
        for (int i = 0; i < BW_ROW; i++) begin
            col = i >> lsa_eff;
            if (col < NUM_COL) begin
                mask_exp[i] = row_colmask[col[BW_COL-1:0]];
            end
        end
    end

    ervp_barrel_shifter #(
        .BW_DATA  (BW_ROW),
        .BW_SHAMT (BW_OFFSET)
    ) u_data_shifter (
        .data_in  (row_data),
        .shamt    (eff_offset),
        .data_out (data_sh)
    );

    ervp_barrel_shifter #(
        .BW_DATA  (BW_ROW),
        .BW_SHAMT (BW_OFFSET)
    ) u_mask_shifter (
        .data_in  (mask_exp),
        .shamt    (eff_offset),
        .data_out (mask_sh)
    );

    assign row_ready = (state == ST_IDLE) && !done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            beats    <= '0;
            data_buf <= '0;
            mask_buf <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (row_valid && row_ready) begin
                        data_buf <= data_sh;
                        mask_buf <= mask_sh;
                        beat_cnt <= '0;
                        beats    <= {1'b0, row_alen} + 9'd1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wready) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (wlast) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Beats past the end of the row buffer fall through with no match and stay zero.
    always_comb begin
        data_slice = '0;
        mask_slice = '0;
        for (int b = 0; b < RATIO; b++) begin
            if (beat_cnt == BW_BEAT'(b)) begin
                data_slice = data_buf[b*BW_AXI_DATA +: BW_AXI_DATA];
                mask_slice = mask_buf[b*BW_AXI_DATA +: BW_AXI_DATA];
            end
        end
    end

    dca_wdata_strobe_gen #(
        .BW_AXI_DATA (BW_AXI_DATA)
    ) u_strobe_gen (
        .mask_slice (mask_slice),
        .wstrb      (strb_raw)
    );

    assign wvalid = (state == ST_SEND);
    assign wdata  = wvalid ? data_slice : '0;
    assign wstrb  = wvalid ? strb_raw : '0;
    assign wlast  = wvalid && (beat_cnt == beats - 9'd1);

endmodule
